// File: rtl/ripple_pkg.sv
// Shared definitions for the ripple counter sampler.
//   RIPPLE_WIDTH    - default width of the ripple counter being sampled
//   SYNC_STAGES_MIN - shallowest synchroniser chain that is safe to use
//   buf_state_t     - one-entry output buffer state
package ripple_pkg;

    localparam int RIPPLE_WIDTH    = 4;
    localparam int SYNC_STAGES_MIN = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/ripple_count_sync.sv
// Multi-bit flop chain bringing the raw ripple count into the clk domain.
// Bits may land on different edges while the counter ripples; the stability
// filter downstream rejects those skewed words, so no per-bit handshake is needed.
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset, clears every stage
//   d     - raw asynchronous count
//   q     - final synchroniser stage (s_sync)
module count_sync #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++)
                chain[i] <= chain[i-1];
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/ripple_count_sampler.sv
// Samples a free-running ripple counter, discards transient ripple values and
// hands each settled count change to a consumer through a one-entry buffer.
//   clk, rst      - system clock (rising) / asynchronous active-high reset
//   cnt_in        - raw ripple counter output, asynchronous to clk
//   cmp_val       - quasi-static compare value
//   out_ready     - consumer accepts the buffered entry
//   clr_overrun   - clears the sticky overrun flag
//   out_valid     - buffered entry present
//   out_count     - settled count
//   out_delta     - count advance since the previous committed value (mod 2^WIDTH)
//   out_wrap      - settled count is below the previous committed value
//   match         - one-cycle pulse when a loaded count equals cmp_val
//   overrun       - sticky: a settled change was held off by a stalled full buffer
module ripple_count_sampler
    import ripple_pkg::*;
#(
    parameter int WIDTH         = RIPPLE_WIDTH,
    parameter int SYNC_STAGES   = SYNC_STAGES_MIN,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic             out_ready,
    input  logic             clr_overrun,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_count,
    output logic [WIDTH-1:0] out_delta,
    output logic             out_wrap,
    output logic             match,
    output logic             overrun
);

    localparam int            RW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);

    logic [WIDTH-1:0] s_sync;
    logic [WIDTH-1:0] s_prev;
    logic [WIDTH-1:0] last_cnt;
    logic [RW-1:0]    run_q, run_d;
    logic             commit;
    logic             load;
    logic             blocked;
    buf_state_t       state_q, state_d;

    count_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (cnt_in),
        .q   (s_sync)
    );

    // The run counts edges at which s_sync repeats its previous value. The
    // commit decision uses the post-edge run value so a count settled before
    // edge 0 commits at edge SYNC_STAGES+STABLE_CYCLES.
    always_comb begin
        run_d = run_q;
        if (s_sync != s_prev)
            run_d = '0;
        else if (run_q != RUN_MAX)
            run_d = run_q + RW'(1);
    end

    // The run saturates, so a held-off commit stays pending until the buffer
    // can take it and then carries the delta over every missed count.
    assign commit = (run_d == RUN_MAX) && (s_sync != last_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_prev <= '0;
            run_q  <= '0;
        end else begin
            s_prev <= s_sync;
            run_q  <= run_d;
        end
    end

    // Buffer FSM: next state and load/blocked decisions.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        blocked = 1'b0;
        case (state_q)
            EMPTY: begin
                if (commit) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    if (commit)
                        load = 1'b1;     // back-to-back reload, no bubble
                    else
                        state_d = EMPTY;
                end else if (commit) begin
                    blocked = 1'b1;      // entry must stay stable while stalled
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    assign out_valid = (state_q == FULL);

    // Entry fields and last_cnt only advance on an actual load, so a blocked
    // commit leaves last_cnt at the value the consumer last saw.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_count <= '0;
            out_delta <= '0;
            out_wrap  <= 1'b0;
            last_cnt  <= '0;
        end else if (load) begin
            out_count <= s_sync;
            out_delta <= WIDTH'(s_sync - last_cnt);
            out_wrap  <= (s_sync < last_cnt);
            last_cnt  <= s_sync;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            match <= 1'b0;
        else
            match <= load && (s_sync == cmp_val);
    end

    // Set has priority over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overrun <= 1'b0;
        else if (blocked)
            overrun <= 1'b1;
        else if (clr_overrun)
            overrun <= 1'b0;
    end

endmodule

// File: tb/tb_ripple_count_sampler.sv
module tb_ripple_count_sampler;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int ST = 2;
    localparam int WN = SS + ST + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] cnt_in, cmp_val;
    logic         out_ready, clr_overrun;
    logic         out_valid, out_wrap, match, overrun;
    logic [W-1:0] out_count, out_delta;

    ripple_count_sampler #(.WIDTH(W), .SYNC_STAGES(SS), .STABLE_CYCLES(ST)) dut (
        .clk         (clk),
        .rst         (rst),
        .cnt_in      (cnt_in),
        .cmp_val     (cmp_val),
        .out_ready   (out_ready),
        .clr_overrun (clr_overrun),
        .out_valid   (out_valid),
        .out_count   (out_count),
        .out_delta   (out_delta),
        .out_wrap    (out_wrap),
        .match       (match),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: history of sampled counts (newest first) plus buffer view.
    logic [W-1:0] win[$];
    logic         m_valid, m_wrap, m_match, m_overrun;
    logic [W-1:0] m_count, m_delta, m_last;

    // Observed handshakes / match pulses for the directed scenario checks.
    int           hs, nmatch;
    logic [W-1:0] hs_count, hs_delta;
    logic         hs_wrap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic m_reset();
        win = {};
        for (int i = 0; i < WN; i++) win.push_front('0);
        m_valid = 0; m_wrap = 0; m_match = 0; m_overrun = 0;
        m_count = 0; m_delta = 0; m_last = 0;
    endtask

    // A value counts as settled once the synchronised view has shown it for
    // ST+1 consecutive samples; the newest SS samples are still in flight.
    task automatic model_edge();
        logic         settled, commit, load;
        logic [W-1:0] s;
        win.push_front(cnt_in);
        void'(win.pop_back());
        s = win[SS];
        settled = 1'b1;
        for (int i = SS + 1; i <= SS + ST; i++)
            if (win[i] != s) settled = 1'b0;
        commit = settled && (s != m_last);
        load   = commit && (!m_valid || out_ready);
        if (commit && m_valid && !out_ready) m_overrun = 1'b1;
        else if (clr_overrun)                m_overrun = 1'b0;
        if (m_valid && out_ready && !commit) m_valid = 1'b0;
        m_match = load && (s == cmp_val);
        if (load) begin
            m_valid = 1'b1;
            m_count = s;
            m_delta = s - m_last;
            m_wrap  = (s < m_last);
            m_last  = s;
        end
    endtask

    task automatic chk_all();
        chk("valid", out_valid, m_valid);
        chk("match", match, m_match);
        chk("overrun", overrun, m_overrun);
        if (m_valid) begin
            chk("count", out_count, m_count);
            chk("delta", out_delta, m_delta);
            chk("wrap", out_wrap, m_wrap);
        end
        if (out_valid && out_ready) begin
            hs++; hs_count = out_count; hs_delta = out_delta; hs_wrap = out_wrap;
        end
        if (match) nmatch++;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (rst) m_reset();
            else     model_edge();
            #1;
            chk_all();
        end
    endtask

    initial begin
        rst = 1'b1; cnt_in = 0; cmp_val = 4'd9; out_ready = 1'b1; clr_overrun = 1'b0;
        m_reset();
        hs = 0; nmatch = 0; hs_count = 0; hs_delta = 0; hs_wrap = 0;
        step(2);
        rst = 1'b0;
        step(3);

        // Fill the buffer, then reset with cnt_in=5: outputs clear at once.
        out_ready = 1'b0; cnt_in = 4'd5;
        step(8);
        chk("full_before_reset", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        m_reset();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_count", out_count, 4'd0);
        chk("rst_delta", out_delta, 4'd0);
        chk("rst_wrap", out_wrap, 1'b0);
        chk("rst_match", match, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        step(2);
        cnt_in = 0; out_ready = 1'b1;
        rst = 1'b0;
        hs = 0;
        step(20);
        chk("idle_no_entry", hs, 0);

        // Single step 0 -> 1, valid exactly one cycle.
        cnt_in = 4'd1; hs = 0;
        step(8);
        chk("single_entries", hs, 1);
        chk("single_count", hs_count, 4'd1);
        chk("single_delta", hs_delta, 4'd1);
        chk("single_wrap", hs_wrap, 1'b0);

        // Transient ripple 7 -> 6 -> 4 -> 0 -> 8.
        cnt_in = 4'd7; step(8);
        hs = 0;
        cnt_in = 4'd6; step(1);
        cnt_in = 4'd4; step(1);
        cnt_in = 4'd0; step(1);
        cnt_in = 4'd8; step(8);
        chk("ripple_entries", hs, 1);
        chk("ripple_count", hs_count, 4'd8);
        chk("ripple_delta", hs_delta, 4'd1);

        // Wrap 15 -> 0 with a compare match on 0.
        cnt_in = 4'd15; step(8);
        cmp_val = 4'd0; hs = 0; nmatch = 0;
        cnt_in = 4'd0; step(8);
        chk("wrap_count", hs_count, 4'd0);
        chk("wrap_delta", hs_delta, 4'd1);
        chk("wrap_flag", hs_wrap, 1'b1);
        chk("wrap_match_pulses", nmatch, 1);

        // Backpressure: 1, 2, 3 while stalled.
        cmp_val = 4'd9; out_ready = 1'b0;
        cnt_in = 4'd1; step(10);
        cnt_in = 4'd2; step(10);
        cnt_in = 4'd3; step(10);
        chk("bp_held_count", out_count, 4'd1);
        chk("bp_overrun", overrun, 1'b1);
        out_ready = 1'b1; step(1);
        chk("bp_reload_count", out_count, 4'd3);
        chk("bp_reload_delta", out_delta, 4'd2);
        step(3);
        clr_overrun = 1'b1; step(1);
        clr_overrun = 1'b0;
        chk("bp_overrun_clr", overrun, 1'b0);

        // Reset mid-operation while FULL and stalled.
        out_ready = 1'b0; cnt_in = 4'd9; step(8);
        rst = 1'b1;
        #1;
        m_reset();
        chk("midrst_valid", out_valid, 1'b0);
        cnt_in = 4'd3; step(1);
        rst = 1'b0; out_ready = 1'b1; hs = 0;
        step(8);
        chk("midrst_entries", hs, 1);
        chk("midrst_count", hs_count, 4'd3);
        chk("midrst_delta", hs_delta, 4'd3);

        // Randomised holds, backpressure, clears and compare values.
        for (int it = 0; it < 200; it++) begin
            cnt_in      = W'($urandom_range(0, 15));
            out_ready   = ($urandom_range(0, 3) != 0);
            clr_overrun = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) cmp_val = W'($urandom_range(0, 15));
            step($urandom_range(1, 6));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ripple_count_sampler.md
Name: ripple_count_sampler

Overview:
- Downstream consumer of the 4-bit negedge ripple counter.
- The ripple counter's output bits settle asynchronously and pass through transient intermediate values (e.g. 7 -> 6 -> 4 -> 0 -> 8). This block synchronises that count into the system clk domain and filters out transients.
- It presents each settled count change on a valid/ready output with a one-entry holding buffer.
- It reports the count delta since the last committed value, counter wrap, and a compare match.

Parameters:
- WIDTH, 4, counter width in bits.
- SYNC_STAGES, 2, synchroniser flops per bit; minimum 2.
- STABLE_CYCLES, 2, consecutive clk edges s_sync must hold an unchanged value before commit; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cnt_in  in  WIDTH  raw ripple counter output; asynchronous to clk.
- cmp_val  in  WIDTH  compare value; quasi-static.
- out_ready  in  1  consumer accepts the buffered entry.
- clr_overrun  in  1  clears the sticky overrun flag.
- out_valid  out  1  buffered entry present.
- out_count  out  WIDTH  settled count.
- out_delta  out  WIDTH  (out_count - previous committed count) mod 2^WIDTH.
- out_wrap  out  1  out_count < previous committed count.
- match  out  1  one-cycle pulse: committed count == cmp_val.
- overrun  out  1  sticky: a commit was blocked by a full, stalled buffer.

Behaviour:
- Reset: every flop clears immediately.
  - Outputs: out_valid=0, out_count=0, out_delta=0, out_wrap=0, match=0, overrun=0.
  - Internals: sync chain=0, last_cnt=0, stability run=0, FSM=EMPTY.
  - Reset mid-operation discards any buffered entry. Because last_cnt=0 matches the counter's own reset value, a counter reset alongside this block produces no commit.
- Synchroniser: each bit of cnt_in passes through SYNC_STAGES flops; s_sync is the final stage.
- Stability filter: a run counter tracks the number of consecutive edges at which s_sync equals its value at the previous edge, saturating at STABLE_CYCLES.
- Commit condition: s_sync has been stable for STABLE_CYCLES edges AND s_sync != last_cnt.
- Latency: cnt_in settles before edge 0 -> out_valid is high after edge SYNC_STAGES+STABLE_CYCLES (edge 4 with defaults).
- On commit, at a single registered edge:
  - out_count <= s_sync.
  - out_delta <= s_sync - last_cnt, modulo 2^WIDTH.
  - out_wrap <= (s_sync < last_cnt).
  - match <= (s_sync == cmp_val), high for exactly one cycle.
  - last_cnt <= s_sync.
- Buffer FSM, states EMPTY and FULL; out_valid = (state == FULL):
  - EMPTY & commit -> load entry, go FULL.
  - FULL & out_ready & !commit -> EMPTY.
  - FULL & out_ready & commit -> reload with the new entry, stay FULL (back-to-back, no bubble).
  - FULL & !out_ready & commit -> no load. last_cnt is NOT updated; overrun <= 1. Output fields stay stable while out_valid && !out_ready.
- Blocked commit: the condition remains true, so the latest settled value commits on the edge after the buffer drains. Its out_delta covers all counts missed during the stall.
- overrun: cleared by clr_overrun. When set and clear occur on the same edge, set wins.
- Any change of s_sync restarts the stability run. Intermediate ripple values shorter than STABLE_CYCLES are never committed.
- Wrap example: 15 -> 0 gives out_delta=1, out_wrap=1.

Decomposition:
- Shared package ripple_pkg:
  - RIPPLE_WIDTH=4 default.
  - Buffer state enum {EMPTY, FULL}.
  - SYNC_STAGES_MIN=2.
- One sub-module: count_sync.
  - Parameterised SYNC_STAGES-deep, WIDTH-wide flop chain with asynchronous reset.
  - A multi-bit chain is acceptable because the stability filter rejects skew between bits.

Test Plan:
- Reset:
  - Assert rst with cnt_in=5 and the buffer FULL -> all outputs 0 immediately.
  - Release rst, hold cnt_in=0 for 20 cycles -> out_valid stays 0.
- Single step:
  - out_ready=1, cnt_in 0 -> 1, held -> out_valid high for exactly 1 cycle after edge 4, with out_count=1, out_delta=1, out_wrap=0.
- Transient rejection:
  - last_cnt=7; cnt_in steps 6, 4, 0 (one clk cycle each), then 8 held -> exactly one entry: out_count=8, out_delta=1.
  - No entry for 6, 4 or 0.
- Wrap and match:
  - last_cnt=15, cmp_val=0, cnt_in -> 0 -> out_count=0, out_delta=1, out_wrap=1.
  - match pulses 1 cycle, aligned with out_valid rising.
- Backpressure:
  - out_ready=0; cnt_in 1, then 2, then 3, each held 10 cycles -> entry count=1 stays stable and overrun=1.
  - Raise out_ready -> count=1 accepted; next entry is count=3, out_delta=2.
  - Pulse clr_overrun -> overrun=0.
- Reset mid-operation:
  - Assert rst while FULL with out_ready=0 -> out_valid=0 immediately.
  - Release with cnt_in=3 -> one entry: out_count=3, out_delta=3.
